// File: rtl/prisoners_vault_if.sv
// prisoners_vault_if: request/response bundle between a vault client and the prisoners_vault core.
interface prisoners_vault_if #(
  parameter int DATA_W    = 8,
  parameter int SLOTS     = 4,
  parameter int MAX_TRIES = 3
);
  logic [DATA_W-1:0]                  input_data;
  logic [$clog2(SLOTS)-1:0]           slot_sel;
  logic [31:0]                        guard_key;
  logic                               load;
  logic                               compare;
  logic                               clear;
  logic                               busy;
  logic                               result_valid;
  logic                               match;
  logic [SLOTS-1:0]                   found;
  logic [$clog2(MAX_TRIES+1)-1:0]     tries_left;
  logic                               locked;
  logic                               fail;
  logic                               key_err;
  modport master (
    output input_data, slot_sel, guard_key, load, compare, clear,
    input  busy, result_valid, match, found, tries_left, locked, fail, key_err
  );
  modport slave (
    input  input_data, slot_sel, guard_key, load, compare, clear,
    output busy, result_valid, match, found, tries_left, locked, fail, key_err
  );
endinterface

// File: rtl/prisoners_vault.sv
// prisoners_vault: keyed secret store with guess comparison, try counting and timed lockout.
module prisoners_vault #(
  parameter int          DATA_W      = 8,
  parameter int          SLOTS       = 4,
  parameter logic [31:0] GUARD_KEY   = 32'hCAFEFACE,
  parameter int          MAX_TRIES   = 3,
  parameter int          LOCK_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  prisoners_vault_if.slave bus
);
  localparam int SW = $clog2(SLOTS);
  localparam int SD = 1 << SW;
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CYCLES);
  typedef enum logic [1:0] {IDLE, EVAL, LOCKOUT} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [SD];
  logic [SD-1:0] valid, found, ok;
  logic [TW-1:0] tries;
  logic [CW-1:0] lock_cnt;
  logic match_q, fail, key_err;
  logic key_ok, kclr, in_range, hit_now, take, wr;
  always_comb begin
    for (int i = 0; i < SD; i++) ok[i] = i < SLOTS;
    key_ok = bus.guard_key == GUARD_KEY;
    kclr = bus.clear && key_ok;
    in_range = ok[bus.slot_sel];
    hit_now = in_range && valid[bus.slot_sel] && mem[bus.slot_sel] == bus.input_data;
    // A compare may also be accepted in EVAL so results can stream back to back
    take = bus.compare && !kclr && (state == IDLE || (state == EVAL && tries != '0));
    wr = state == IDLE && bus.load && key_ok && !kclr && !bus.compare && in_range;
    state_n = kclr ? IDLE :
              state == IDLE ? (take ? EVAL : IDLE) :
              state == EVAL ? (tries == '0 ? LOCKOUT : take ? EVAL : IDLE) :
              (lock_cnt <= CW'(1) ? IDLE : LOCKOUT);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SD; i++) mem[i] <= '0;
      valid <= '0;
      found <= '0;
      fail <= 1'b0;
      tries <= TRIES_MAX;
      lock_cnt <= '0;
      match_q <= 1'b0;
      key_err <= 1'b0;
    end else begin
      key_err <= (bus.load || bus.clear) && !key_ok;
      if (kclr) begin
        for (int i = 0; i < SD; i++) mem[i] <= '0;
        valid <= '0;
        found <= '0;
        fail <= 1'b0;
        tries <= TRIES_MAX;
        lock_cnt <= '0;
      end else begin
        if (take) begin
          match_q <= hit_now;
          if (hit_now) begin
            found[bus.slot_sel] <= 1'b1;
            tries <= TRIES_MAX;
          end else if (tries != '0) tries <= tries - TW'(1);
        end
        if (wr) begin
          mem[bus.slot_sel] <= bus.input_data;
          valid[bus.slot_sel] <= 1'b1;
          found[bus.slot_sel] <= 1'b0;
        end
        if (state == EVAL && tries == '0) begin
          fail <= 1'b1;
          lock_cnt <= LOCK_MAX;
        end
        if (state == LOCKOUT) begin
          if (lock_cnt != '0) lock_cnt <= lock_cnt - CW'(1);
          if (lock_cnt <= CW'(1)) tries <= TRIES_MAX;
        end
      end
    end
  end
  // The result is withdrawn if reset or a keyed clear lands on the EVAL cycle
  assign bus.result_valid = state == EVAL && !rst && !kclr;
  assign bus.match = bus.result_valid && match_q;
  assign bus.busy = state != IDLE;
  assign bus.locked = state == LOCKOUT;
  assign bus.found = found[SLOTS-1:0];
  assign bus.tries_left = tries;
  assign bus.fail = fail;
  assign bus.key_err = key_err;
endmodule
